hazard_ctrl_mc: RTL and testbench

Parametrised hazard detection and forwarding controller for the 5-stage core (IF/ID/EXE/MEM/WB), extended with a fixed-latency multi-cycle unit (MUL/DIV).
- Keeps the existing load-use stall, branch flush and EXE/MEM forwarding.
- Adds a per-register pending scoreboard, RAW/WAW/structural stalls against the multi-cycle unit, a completion bypass and a saturating stall counter.
- Sits beside the ID stage and drives every pipeline-register enable/flush and the operand-mux selects.

---
 rtl/hazard_pkg.sv | 20 ++
 rtl/mc_scoreboard.sv | 69 ++++++
 rtl/hazard_ctrl_mc.sv | 148 ++++++++++++++
 tb/tb_hazard_ctrl_mc.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard/forwarding controller: operand-select
// codes and a constant-evaluable ceil(log2) helper for sizing counters.
package hazard_pkg;

  typedef enum logic [2:0] {
    FWD_RF   = 3'b000,
    FWD_EXE  = 3'b001,
    FWD_MEM  = 3'b010,
    FWD_LOAD = 3'b011,
    FWD_MC   = 3'b100
  } fwd_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/mc_scoreboard.sv
// Tracks the single in-flight multi-cycle op: per-register pending bits,
// the latency countdown, its destination and whether it will write back.
module mc_scoreboard
  import hazard_pkg::*;
#(
  parameter int NREG   = 32,
  parameter int AW     = 5,
  parameter int MC_LAT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_issue,
  input  logic            i_set_en,
  input  logic [AW-1:0]   i_set_rd,
  output logic [NREG-1:0] o_pending,
  output logic            o_mc_busy,
  output logic            o_mc_wb,
  output logic [AW-1:0]   o_mc_rd_wb,
  output logic            o_cnt_gt1
);

  localparam int CW = clog2(MC_LAT + 1);

  logic [CW-1:0]   r_cnt;
  logic [AW-1:0]   r_rd;
  logic            r_wb_valid;
  logic [NREG-1:0] r_pending;
  logic [NREG-1:0] w_pending_next;
  logic            w_mc_wb;

  assign w_mc_wb    = (r_cnt == CW'(1)) && r_wb_valid;
  assign o_mc_wb    = w_mc_wb;
  assign o_mc_busy  = (r_cnt != '0);
  assign o_mc_rd_wb = r_rd;
  assign o_cnt_gt1  = (r_cnt > CW'(1));
  assign o_pending  = r_pending;

  // Per-register pending update: a new issue to a register wins over the
  // completing op clearing that same register (back-to-back same rd).
  for (genvar gi = 0; gi < NREG; gi++) begin : g_pend
    assign w_pending_next[gi] =
        (i_issue && i_set_en && (i_set_rd == AW'(gi))) ? 1'b1 :
        (w_mc_wb && (r_rd == AW'(gi)))                 ? 1'b0 :
                                                         r_pending[gi];
  end

  // Pending vector register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pending <= '0;
    else        r_pending <= w_pending_next;
  end

  // Latency countdown, destination and write-back qualifier for the op in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_rd       <= '0;
      r_wb_valid <= 1'b0;
    end else if (i_issue) begin
      r_cnt      <= CW'(MC_LAT);
      r_rd       <= i_set_en ? i_set_rd : '0;
      r_wb_valid <= i_set_en;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CW'(1);
      if (r_cnt == CW'(1)) r_wb_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/hazard_ctrl_mc.sv
// Hazard detection and forwarding for the 5-stage core with a fixed-latency
// multi-cycle unit: stall/flush generation, operand selects, stall counter.
module hazard_ctrl_mc
  import hazard_pkg::*;
#(
  parameter int NREG   = 32,
  parameter int AW     = 5,
  parameter int MC_LAT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          valid_ID,
  input  logic [AW-1:0] rs1_ID,
  input  logic [AW-1:0] rs2_ID,
  input  logic [AW-1:0] rd_ID,
  input  logic          rs1use_ID,
  input  logic          rs2use_ID,
  input  logic          rd_w_ID,
  input  logic          store_ID,
  input  logic          mc_ID,
  input  logic          Branch_ID,
  input  logic [AW-1:0] rd_EXE,
  input  logic [AW-1:0] rd_MEM,
  input  logic [AW-1:0] rs2_EXE,
  input  logic          rd_w_EXE,
  input  logic          rd_w_MEM,
  input  logic          load_EXE,
  input  logic          load_MEM,
  input  logic          store_EXE,
  output logic          PC_EN_IF,
  output logic          reg_FD_EN,
  output logic          reg_FD_stall,
  output logic          reg_FD_flush,
  output logic          reg_DE_EN,
  output logic          reg_DE_flush,
  output logic          reg_EM_EN,
  output logic          reg_EM_flush,
  output logic          reg_MW_EN,
  output logic [2:0]    forward_ctrl_A,
  output logic [2:0]    forward_ctrl_B,
  output logic          forward_ctrl_ls,
  output logic          mc_start,
  output logic          mc_busy,
  output logic          mc_wb,
  output logic [AW-1:0] mc_rd_wb,
  output logic [31:0]   stall_cnt
);

  logic [NREG-1:0] w_pending;
  logic            w_cnt_gt1;
  logic            w_done1, w_done2, w_done_rd;
  logic            w_load_use, w_raw, w_waw, w_struct;
  logic            w_stall, w_issue, w_set_en;
  logic [31:0]     r_stall_cnt;

  function automatic logic hit(input logic [AW-1:0] x, input logic [AW-1:0] r);
    return (x != '0) && (x == r);
  endfunction

  // Priority: youngest producer first, multi-cycle completion last.
  function automatic fwd_e fwd_pick(input logic use_f, input logic [AW-1:0] rs,
                                    input logic e_w, input logic e_ld, input logic [AW-1:0] e_rd,
                                    input logic m_w, input logic m_ld, input logic [AW-1:0] m_rd,
                                    input logic done_f);
    fwd_e sel;
    sel = FWD_RF;
    if (use_f) begin
      if (e_w && hit(rs, e_rd) && !e_ld)     sel = FWD_EXE;
      else if (m_w && hit(rs, m_rd) && !m_ld) sel = FWD_MEM;
      else if (m_w && hit(rs, m_rd) && m_ld)  sel = FWD_LOAD;
      else if (done_f)                        sel = FWD_MC;
    end
    return sel;
  endfunction

  assign w_done1   = mc_wb && hit(rs1_ID, mc_rd_wb);
  assign w_done2   = mc_wb && hit(rs2_ID, mc_rd_wb);
  assign w_done_rd = mc_wb && hit(rd_ID, mc_rd_wb);

  // A store only needs rs2 as data, which MEM-load forwarding supplies later.
  assign w_load_use = load_EXE && rd_w_EXE &&
                      ((rs1use_ID && hit(rs1_ID, rd_EXE)) ||
                       (rs2use_ID && hit(rs2_ID, rd_EXE) && !store_ID));
  assign w_raw      = (rs1use_ID && w_pending[rs1_ID] && !w_done1) ||
                      (rs2use_ID && w_pending[rs2_ID] && !w_done2);
  assign w_waw      = rd_w_ID && (rd_ID != '0) && w_pending[rd_ID] && !w_done_rd;
  assign w_struct   = mc_ID && w_cnt_gt1;

  assign w_stall  = valid_ID && (w_load_use || w_raw || w_waw || w_struct);
  assign w_issue  = valid_ID && !w_stall && mc_ID;
  assign w_set_en = rd_w_ID && (rd_ID != '0);

  mc_scoreboard #(
    .NREG   (NREG),
    .AW     (AW),
    .MC_LAT (MC_LAT)
  ) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_issue    (w_issue),
    .i_set_en   (w_set_en),
    .i_set_rd   (rd_ID),
    .o_pending  (w_pending),
    .o_mc_busy  (mc_busy),
    .o_mc_wb    (mc_wb),
    .o_mc_rd_wb (mc_rd_wb),
    .o_cnt_gt1  (w_cnt_gt1)
  );

  // Pipeline control: a stall holds IF/ID and bubbles ID/EX; it outranks a taken branch.
  always_comb begin
    PC_EN_IF     = 1'b1;
    reg_FD_EN    = 1'b1;
    reg_FD_stall = 1'b0;
    reg_FD_flush = 1'b0;
    reg_DE_EN    = 1'b1;
    reg_DE_flush = 1'b0;
    reg_EM_EN    = 1'b1;
    reg_EM_flush = 1'b0;
    reg_MW_EN    = 1'b1;
    mc_start     = w_issue;
    if (w_stall) begin
      PC_EN_IF     = 1'b0;
      reg_FD_stall = 1'b1;
      reg_DE_flush = 1'b1;
    end else if (Branch_ID) begin
      reg_FD_flush = 1'b1;
    end
  end

  // Operand selects and store-data forwarding from a load in MEM.
  always_comb begin
    forward_ctrl_A  = fwd_pick(rs1use_ID, rs1_ID, rd_w_EXE, load_EXE, rd_EXE,
                               rd_w_MEM, load_MEM, rd_MEM, w_done1);
    forward_ctrl_B  = fwd_pick(rs2use_ID, rs2_ID, rd_w_EXE, load_EXE, rd_EXE,
                               rd_w_MEM, load_MEM, rd_MEM, w_done2);
    forward_ctrl_ls = store_EXE && load_MEM && rd_w_MEM && hit(rs2_EXE, rd_MEM);
  end

  // Saturating count of qualified stall cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               r_stall_cnt <= '0;
    else if (w_stall && (r_stall_cnt != '1))  r_stall_cnt <= r_stall_cnt + 32'd1;
  end

  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Scoreboard bench for hazard_ctrl_mc: each driven cycle pushes its expected
// outputs, a negedge monitor pops and compares them.
module tb_hazard_ctrl_mc;
  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int LAT  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic valid_ID, rs1use_ID, rs2use_ID, rd_w_ID, store_ID, mc_ID, Branch_ID;
  logic [AW-1:0] rs1_ID, rs2_ID, rd_ID, rd_EXE, rd_MEM, rs2_EXE;
  logic rd_w_EXE, rd_w_MEM, load_EXE, load_MEM, store_EXE;
  logic PC_EN_IF, reg_FD_EN, reg_FD_stall, reg_FD_flush, reg_DE_EN, reg_DE_flush;
  logic reg_EM_EN, reg_EM_flush, reg_MW_EN, forward_ctrl_ls, mc_start, mc_busy, mc_wb;
  logic [2:0] forward_ctrl_A, forward_ctrl_B;
  logic [AW-1:0] mc_rd_wb;
  logic [31:0] stall_cnt;

  always #5 clk = ~clk;

  hazard_ctrl_mc #(.NREG(NREG), .AW(AW), .MC_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .valid_ID(valid_ID),
    .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .rd_ID(rd_ID),
    .rs1use_ID(rs1use_ID), .rs2use_ID(rs2use_ID), .rd_w_ID(rd_w_ID),
    .store_ID(store_ID), .mc_ID(mc_ID), .Branch_ID(Branch_ID),
    .rd_EXE(rd_EXE), .rd_MEM(rd_MEM), .rs2_EXE(rs2_EXE),
    .rd_w_EXE(rd_w_EXE), .rd_w_MEM(rd_w_MEM), .load_EXE(load_EXE),
    .load_MEM(load_MEM), .store_EXE(store_EXE),
    .PC_EN_IF(PC_EN_IF), .reg_FD_EN(reg_FD_EN), .reg_FD_stall(reg_FD_stall),
    .reg_FD_flush(reg_FD_flush), .reg_DE_EN(reg_DE_EN), .reg_DE_flush(reg_DE_flush),
    .reg_EM_EN(reg_EM_EN), .reg_EM_flush(reg_EM_flush), .reg_MW_EN(reg_MW_EN),
    .forward_ctrl_A(forward_ctrl_A), .forward_ctrl_B(forward_ctrl_B),
    .forward_ctrl_ls(forward_ctrl_ls), .mc_start(mc_start), .mc_busy(mc_busy),
    .mc_wb(mc_wb), .mc_rd_wb(mc_rd_wb), .stall_cnt(stall_cnt)
  );

  typedef struct {
    logic valid, rs1use, rs2use, rd_w, store, mc, br;
    logic [4:0] rs1, rs2, rd, rd_exe, rd_mem, rs2_exe;
    logic rd_w_exe, rd_w_mem, load_exe, load_mem, store_exe;
  } vec_t;

  typedef struct {
    int id;
    logic pc_en, fd_stall, fd_flush, de_flush, start, busy, wb, ls;
    logic [4:0] wb_rd;
    logic [2:0] fa, fb;
    logic [31:0] scnt;
  } exp_t;

  exp_t q[$];
  int n_chk = 0;
  int n_pass = 0;
  int n_txn = 0;

  // Reference state: a register is still outstanding while its ready cycle
  // lies in the future; the unit completes at m_wb_cyc.
  int m_cyc = 0;
  int m_ready[NREG];
  int m_wb_cyc;
  bit m_wb_has;
  logic [4:0] m_rd;
  logic [31:0] m_scnt;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
  endtask

  function automatic bit hitf(input logic [4:0] x, input logic [4:0] r);
    return (x != 5'd0) && (x == r);
  endfunction

  function automatic logic [2:0] fsel(input logic u, input logic [4:0] rs, input vec_t v,
                                      input bit wb, input logic [4:0] wrd);
    if (!u) return 3'b000;
    if (v.rd_w_exe && hitf(rs, v.rd_exe) && !v.load_exe) return 3'b001;
    if (v.rd_w_mem && hitf(rs, v.rd_mem)) return v.load_mem ? 3'b011 : 3'b010;
    if (wb && hitf(rs, wrd)) return 3'b100;
    return 3'b000;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NREG; i++) m_ready[i] = -1;
    m_wb_cyc = -1;
    m_wb_has = 1'b0;
    m_rd     = '0;
    m_scnt   = '0;
  endtask

  function automatic vec_t nop();
    vec_t v;
    v = '{default: '0};
    return v;
  endfunction

  function automatic vec_t alu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    vec_t v;
    v = nop();
    v.valid = 1'b1; v.rd_w = 1'b1; v.rs1use = 1'b1; v.rs2use = 1'b1;
    v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    return v;
  endfunction

  function automatic vec_t mul(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    vec_t v;
    v = alu(rd, rs1, rs2);
    v.mc = 1'b1;
    return v;
  endfunction

  // Drive one cycle's inputs, push the expected outputs, advance the model.
  task automatic apply(input vec_t v);
    exp_t e;
    bit lu, raw, waw, strc, st, iss, d1, d2;
    valid_ID = v.valid; rs1_ID = v.rs1; rs2_ID = v.rs2; rd_ID = v.rd;
    rs1use_ID = v.rs1use; rs2use_ID = v.rs2use; rd_w_ID = v.rd_w;
    store_ID = v.store; mc_ID = v.mc; Branch_ID = v.br;
    rd_EXE = v.rd_exe; rd_MEM = v.rd_mem; rs2_EXE = v.rs2_exe;
    rd_w_EXE = v.rd_w_exe; rd_w_MEM = v.rd_w_mem; load_EXE = v.load_exe;
    load_MEM = v.load_mem; store_EXE = v.store_exe;

    e.id    = n_txn++;
    e.wb    = (m_cyc == m_wb_cyc) && m_wb_has;
    e.wb_rd = m_rd;
    e.busy  = (m_cyc <= m_wb_cyc);
    d1 = e.wb && hitf(v.rs1, m_rd);
    d2 = e.wb && hitf(v.rs2, m_rd);
    lu   = v.load_exe && v.rd_w_exe &&
           ((v.rs1use && hitf(v.rs1, v.rd_exe)) || (v.rs2use && hitf(v.rs2, v.rd_exe) && !v.store));
    raw  = (v.rs1use && (m_ready[v.rs1] > m_cyc)) || (v.rs2use && (m_ready[v.rs2] > m_cyc));
    waw  = v.rd_w && (v.rd != 5'd0) && (m_ready[v.rd] > m_cyc);
    strc = v.mc && (m_cyc < m_wb_cyc);
    st   = v.valid && (lu || raw || waw || strc);
    iss  = v.valid && !st && v.mc;
    e.pc_en    = !st;
    e.fd_stall = st;
    e.de_flush = st;
    e.fd_flush = v.br && !st;
    e.start    = iss;
    e.fa   = fsel(v.rs1use, v.rs1, v, e.wb, m_rd);
    e.fb   = fsel(v.rs2use, v.rs2, v, e.wb, m_rd);
    e.ls   = v.store_exe && v.load_mem && v.rd_w_mem && hitf(v.rs2_exe, v.rd_mem);
    e.scnt = m_scnt;
    q.push_back(e);

    if (iss) begin
      m_wb_cyc = m_cyc + LAT;
      m_wb_has = v.rd_w && (v.rd != 5'd0);
      m_rd     = m_wb_has ? v.rd : 5'd0;
      if (m_wb_has) m_ready[v.rd] = m_cyc + LAT;
    end
    if (st && (m_scnt != 32'hFFFF_FFFF)) m_scnt++;
    m_cyc++;
  endtask

  task automatic run(input vec_t v, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      apply(v);
    end
  endtask

  // Compare the oldest expectation against the settled DUT outputs.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("PC_EN_IF", 32'(PC_EN_IF), 32'(e.pc_en));
      chk("reg_FD_stall", 32'(reg_FD_stall), 32'(e.fd_stall));
      chk("reg_FD_flush", 32'(reg_FD_flush), 32'(e.fd_flush));
      chk("reg_DE_flush", 32'(reg_DE_flush), 32'(e.de_flush));
      chk("const_en", 32'({reg_FD_EN, reg_DE_EN, reg_EM_EN, reg_MW_EN, reg_EM_flush}), 32'(5'b11110));
      chk("forward_ctrl_A", 32'(forward_ctrl_A), 32'(e.fa));
      chk("forward_ctrl_B", 32'(forward_ctrl_B), 32'(e.fb));
      chk("forward_ctrl_ls", 32'(forward_ctrl_ls), 32'(e.ls));
      chk("mc_start", 32'(mc_start), 32'(e.start));
      chk("mc_busy", 32'(mc_busy), 32'(e.busy));
      chk("mc_wb", 32'(mc_wb), 32'(e.wb));
      if (e.wb) chk("mc_rd_wb", 32'(mc_rd_wb), 32'(e.wb_rd));
      chk("stall_cnt", stall_cnt, e.scnt);
      $display("txn %0d: stall=%0b fA=%0d fB=%0d ls=%0b start=%0b busy=%0b wb=%0b rd_wb=%0d scnt=%0d",
               e.id, reg_FD_stall, forward_ctrl_A, forward_ctrl_B, forward_ctrl_ls,
               mc_start, mc_busy, mc_wb, mc_rd_wb, stall_cnt);
    end
  end

  initial begin
    vec_t v;
    m_reset();
    apply(nop());
    void'(q.pop_back());
    m_reset();
    m_cyc = 0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", 32'(mc_busy), 32'd0);
    chk("reset_wb", 32'(mc_wb), 32'd0);
    chk("reset_rd_wb", 32'(mc_rd_wb), 32'd0);
    chk("reset_scnt", stall_cnt, 32'd0);
    #2 rst_n = 1'b1;

    // Load-use on rs1, then forwarded from the load in MEM.
    v = alu(6, 5, 1); v.rd_exe = 5; v.rd_w_exe = 1; v.load_exe = 1;
    run(v, 1);
    v = alu(6, 5, 1); v.rd_mem = 5; v.rd_w_mem = 1; v.load_mem = 1;
    run(v, 1);
    // Store data needing the load result: no stall, then store-data forwarding.
    v = nop(); v.valid = 1; v.store = 1; v.rs1use = 1; v.rs2use = 1; v.rs1 = 2; v.rs2 = 5;
    v.rd_exe = 5; v.rd_w_exe = 1; v.load_exe = 1;
    run(v, 1);
    v = nop(); v.store_exe = 1; v.rs2_exe = 5; v.rd_mem = 5; v.rd_w_mem = 1; v.load_mem = 1;
    run(v, 1);
    // EXE ALU and MEM ALU forwarding on both operands.
    v = alu(9, 3, 4); v.rd_exe = 3; v.rd_w_exe = 1; v.rd_mem = 4; v.rd_w_mem = 1;
    run(v, 1);
    // Branch during a load-use stall, then taken once the stall clears.
    v = alu(0, 8, 0); v.rd_w = 0; v.br = 1; v.rd_exe = 8; v.rd_w_exe = 1; v.load_exe = 1;
    run(v, 1);
    v.rd_exe = 0; v.rd_w_exe = 0; v.load_exe = 0; v.rd_mem = 8; v.rd_w_mem = 1; v.load_mem = 1;
    run(v, 1);
    run(nop(), 1);

    // MC RAW: consumer stalls until the completion bypass.
    run(mul(7, 1, 2), 1);
    run(alu(8, 7, 1), 4);
    run(nop(), 2);
    // Structural: second MUL waits for the completing cycle.
    run(mul(10, 1, 2), 1);
    run(mul(11, 3, 4), 4);
    // WAW against the pending x11, then back-to-back same-rd MUL.
    run(alu(11, 1, 2), 4);
    run(mul(12, 1, 2), 1);
    run(mul(12, 3, 4), 4);
    run(alu(13, 12, 0), 5);
    // MUL with no destination: unit busy, no write-back.
    run(mul(0, 1, 2), 1);
    run(nop(), 5);
    // ID not valid: hazards are ignored.
    run(mul(14, 1, 2), 1);
    v = alu(15, 14, 14); v.valid = 0;
    run(v, 2);
    run(nop(), 3);

    // Reset while a MUL to x9 has mc_cnt==2.
    run(mul(9, 1, 2), 1);
    run(nop(), 2);
    @(posedge clk);
    #1;
    apply(nop());
    void'(q.pop_back());
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(mc_busy), 32'd0);
    chk("midrst_scnt", stall_cnt, 32'd0);
    chk("midrst_wb", 32'(mc_wb), 32'd0);
    m_reset();
    #2 rst_n = 1'b1;
    run(alu(3, 9, 0), 1);
    run(nop(), 6);

    // Random traffic over a small register window.
    for (int i = 0; i < 400; i++) begin
      v.valid    = ($urandom_range(0, 7) != 0);
      v.rs1      = 5'($urandom_range(0, 7));
      v.rs2      = 5'($urandom_range(0, 7));
      v.rd       = 5'($urandom_range(0, 7));
      v.rs1use   = 1'($urandom_range(0, 1));
      v.rs2use   = 1'($urandom_range(0, 1));
      v.rd_w     = 1'($urandom_range(0, 1));
      v.store    = 1'($urandom_range(0, 1));
      v.mc       = ($urandom_range(0, 3) == 0);
      v.br       = ($urandom_range(0, 7) == 0);
      v.rd_exe   = 5'($urandom_range(0, 7));
      v.rd_mem   = 5'($urandom_range(0, 7));
      v.rs2_exe  = 5'($urandom_range(0, 7));
      v.rd_w_exe = 1'($urandom_range(0, 1));
      v.rd_w_mem = 1'($urandom_range(0, 1));
      v.load_exe = 1'($urandom_range(0, 1));
      v.load_mem = 1'($urandom_range(0, 1));
      v.store_exe = 1'($urandom_range(0, 1));
      run(v, 1);
    end

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) chk("queue_drain", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
